if_prefetch_stage: RTL
======================

// Module: if_prefetch_stage
// PURPOSE
//  Parametrised instruction-fetch stage with an in-order prefetch queue. Issues sequential fetches to an
//  instruction memory with variable, in-order read latency, buffers returned words, and presents them to ID
//  with valid/freeze flow control. A taken branch redirects fetch, flushes the queue, and drops in-flight responses.
// PARAMETERS
//  ADDRESS_LEN      32  PC / memory address width
//  INSTRUCTION_LEN  32  instruction word width
//  DEPTH            4   prefetch queue entries = max outstanding+buffered fetches (power of 2, >=2)
//  PC_STEP          4   PC increment per instruction
//  RESET_PC         0   first fetch address after reset
// PORTS
//  clk             in   1                clock, rising edge
//  rst             in   1                asynchronous reset, active-low
//  freeze          in   1                ID stall; holds current output word
//  branch_taken    in   1                redirect request from EXE
//  branch_addr     in   ADDRESS_LEN      redirect target
//  imem_req        out  1                fetch request valid
//  imem_addr       out  ADDRESS_LEN      fetch address
//  imem_ready      in   1                memory accepts request this cycle
//  imem_rvalid     in   1                read data valid (in request order)
//  imem_rdata      in   INSTRUCTION_LEN  read data
//  if_valid        out  1                if_pc/if_instruction valid
//  if_pc           out  ADDRESS_LEN      address of presented instruction + PC_STEP
//  if_instruction  out  INSTRUCTION_LEN  presented instruction
// BEHAVIOUR
//  - Reset (rst=0, async): fetch_pc=resp_pc=RESET_PC; queue empty; outstanding=0; discard=0.
//    Outputs while in reset: imem_req=0, if_valid=0, if_pc=0, if_instruction=0.
//  - Credit rule: imem_req = (count + outstanding < DEPTH) && !branch_taken; imem_addr = fetch_pc.
//  - Issue: on imem_req && imem_ready, fetch_pc += PC_STEP (mod 2^ADDRESS_LEN), outstanding += 1.
//  - Response: every imem_rvalid decrements outstanding. If discard>0: word dropped, discard -= 1.
//    Else push {resp_pc+PC_STEP, imem_rdata}; resp_pc += PC_STEP. Queue can never overflow.
//  - Output: if_valid = !empty; head drives if_pc/if_instruction (0 when empty). Pop when if_valid && !freeze.
//    Registered queue: a word pushed in cycle N is visible at earliest in cycle N+1.
//    Push and pop in the same cycle are both performed.
//  - freeze=1: head and if_valid held stable; fetching continues until credits are exhausted.
//    freeze with empty queue has no effect.
//  - branch_taken=1 (priority over freeze, issue, push, pop), at the clock edge:
//    * fetch_pc <= branch_addr, resp_pc <= branch_addr, queue cleared (if_valid=0 next cycle).
//    * A response arriving in the same cycle is dropped.
//    * discard <= outstanding - (imem_rvalid ? 1 : 0). Pre-existing discard is absorbed into that count.
//    * No request is issued in the branch cycle. First target fetch is the next cycle.
//    * First target instruction reaches if_valid no earlier than branch cycle + 2 + memory latency.
//  - Back-to-back branches: the latest target wins; the discard count is recomputed each time.
//  - Counters: count and outstanding are log2(DEPTH)+1 bits wide; each saturates only logically via the credit rule.
//  - Memory shares rst: no response may arrive for requests issued before reset.
// TESTING
//  1. Reset release, imem_ready=1, 1-cycle latency, freeze=0 -> imem_addr 0,4,8,...; if_pc 4,8,12 on consecutive cycles.
//  2. freeze=1 for 10 cycles, DEPTH=4 -> exactly 4 requests issued then imem_req=0; head (if_pc=4) held;
//     after release, 4 words drain in order.
//  3. Latency 3, imem_ready=1 -> at most DEPTH outstanding; no pushed word lost; PCs contiguous.
//  4. branch_taken with branch_addr=0x100 while 2 requests in flight -> those 2 responses dropped;
//     next if_valid shows if_pc=0x104; no stale word ever presented.
//  5. branch_taken on the same cycle as imem_rvalid and freeze=1 -> response dropped, queue flushed,
//     redirect to branch_addr.
//  6. rst low mid-stream with full queue -> immediately if_valid=0, imem_req=0;
//     after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with an in-order prefetch queue.
// Sequential fetches are issued while credits remain (queued words plus
// in-flight requests below DEPTH). Returned words are tagged with their
// next-PC, buffered, and handed to ID under valid/freeze flow control.
// A taken branch redirects fetch, empties the queue, and marks every
// still-outstanding response to be thrown away when it arrives.
module if_prefetch_stage #(
  parameter int                     ADDRESS_LEN     = 32,
  parameter int                     INSTRUCTION_LEN = 32,
  parameter int                     DEPTH           = 4,
  parameter int                     PC_STEP         = 4,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_addr,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ready,
  input  logic                       imem_rvalid,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic                       if_valid,
  output logic [ADDRESS_LEN-1:0]     if_pc,
  output logic [INSTRUCTION_LEN-1:0] if_instruction
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  localparam logic [ADDRESS_LEN-1:0] STEP      = ADDRESS_LEN'(PC_STEP);
  localparam logic [SUM_W-1:0]       CREDITS   = SUM_W'(DEPTH);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);

  // Architectural state
  logic [ADDRESS_LEN-1:0]     fetch_pc;
  logic [ADDRESS_LEN-1:0]     resp_pc;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           outstanding;
  logic [CNT_W-1:0]           discard;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;

  // Queue storage: word and the PC that follows it
  logic [ADDRESS_LEN-1:0]     q_pc    [DEPTH];
  logic [INSTRUCTION_LEN-1:0] q_instr [DEPTH];

  // Per-cycle events
  logic [SUM_W-1:0]           credit_used;
  logic                       issue;
  logic                       drop;
  logic                       push;
  logic                       pop;
  logic [ADDRESS_LEN-1:0]     push_pc;
  logic [CNT_W-1:0]           outstanding_after_resp;

  // Every queued word and every in-flight request consumes one credit, so
  // the queue always has room for whatever is still on its way back.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};

  // Request is forced low during reset and in the redirect cycle.
  assign imem_req  = rst && (credit_used < CREDITS) && !branch_taken;
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_ready;

  // Responses owed to a pre-branch stream are consumed, never queued.
  assign drop    = imem_rvalid && (discard != '0);
  assign push    = imem_rvalid && (discard == '0) && !branch_taken;
  assign push_pc = resp_pc + STEP;

  assign if_valid       = (count != '0);
  assign pop            = if_valid && !freeze && !branch_taken;
  assign if_pc          = if_valid ? q_pc[rd_ptr]    : '0;
  assign if_instruction = if_valid ? q_instr[rd_ptr] : '0;

  // In-flight count after this cycle's response (if any) has retired
  assign outstanding_after_resp = outstanding - CNT_W'(imem_rvalid);

  // Fetch address: redirect on branch, otherwise advance on each accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      fetch_pc <= branch_addr;
    end else if (issue) begin
      fetch_pc <= fetch_pc + STEP;
    end
  end

  // In-flight bookkeeping: outstanding requests and responses still to be thrown away
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (branch_taken) begin
      // Everything still owed belongs to the old stream; any earlier
      // discard count is already part of that total.
      outstanding <= outstanding_after_resp;
      discard     <= outstanding_after_resp;
    end else begin
      outstanding <= outstanding_after_resp + CNT_W'(issue);
      if (drop) begin
        discard <= discard - CNT_ONE;
      end
    end
  end

  // Queue control: pointers, occupancy and the PC tag of the next returned word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_pc <= RESET_PC;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (branch_taken) begin
      resp_pc <= branch_addr;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (push) begin
        resp_pc <= push_pc;
        wr_ptr  <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= push_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule
